// File: rtl/hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit_pkg
//  Description : Shared definitions for the hazard unit. Holds the forwarding
//                select encodings, the scoreboard entry flag record and small
//                helpers used by the scoreboard and the top level.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_unit_pkg;

  // Forwarding select encodings driven on fwd_a_sel / fwd_b_sel
  localparam logic [1:0] FWD_REG = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_MEM = 2'b01;  // operand from MEM-stage result
  localparam logic [1:0] FWD_WB  = 2'b10;  // operand from WB-stage result

  // Per-stage scoreboard flags; the address travels alongside because its
  // width is a parameter of the top level.
  typedef struct packed {
    logic is_branch;
    logic mem_ren;
    logic wen;
    logic valid;
  } sb_flags_t;

  localparam int SB_FLAG_W = $bits(sb_flags_t);

  localparam sb_flags_t SB_BUBBLE = '0;

  // An entry produces a hazard only if it really writes a non-zero register.
  function automatic logic entry_writes(input sb_flags_t flags, input logic addr_nonzero);
    return flags.valid & flags.wen & addr_nonzero;
  endfunction

  // MEM beats WB; the caller has already excluded loads sitting in MEM.
  function automatic logic [1:0] fwd_select(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_REG;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_sb_entry.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_sb_entry
//  Description : One scoreboard stage register (EXE, MEM or WB). Mirrors the
//                controller's stage reset/enable with priority
//                async reset > stage reset > enable (load or bubble) > hold.
//  Ports       : clk, rst_n        clock / asynchronous active-low reset
//                stage_rst_i       clear entry to a bubble
//                stage_en_i        load entry from previous stage
//                bubble_i          when loading, load a bubble instead
//                addr_i, flags_i   previous-stage destination and flags
//                addr_o, flags_o   current entry contents
//  Revision    : 1.0 - initial release
// ============================================================================
import hazard_unit_pkg::*;

module hazard_sb_entry #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stage_rst_i,
  input  logic              stage_en_i,
  input  logic              bubble_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  sb_flags_t         flags_i,
  output logic [ADDR_W-1:0] addr_o,
  output sb_flags_t         flags_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  sb_flags_t         flags_q, flags_d;

  always_comb begin
    addr_d  = addr_q;
    flags_d = flags_q;
    if (stage_rst_i) begin
      addr_d  = '0;
      flags_d = SB_BUBBLE;
    end else if (stage_en_i) begin
      if (bubble_i) begin
        addr_d  = '0;
        flags_d = SB_BUBBLE;
      end else begin
        addr_d  = addr_i;
        flags_d = flags_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      flags_q <= SB_BUBBLE;
    end else begin
      addr_q  <= addr_d;
      flags_q <= flags_d;
    end
  end

  assign addr_o  = addr_q;
  assign flags_o = flags_q;

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit
//  Description : Pipeline hazard unit. Tracks in-flight destinations in an
//                EXE/MEM/WB scoreboard and produces the stall request, the
//                taken-branch flush, operand forwarding selects and saturating
//                stall/flush counters.
//  Config macro: HAZARD_FORWARD_EN
//                  defined   - MEM/WB forwarding, only load-use stalls
//                  undefined - forwarding selects tied to regfile, any RAW
//                              match against EXE/MEM/WB stalls
//  Ports       : clk, rst_n                   clock / async active-low reset
//                id_rs/rt_addr, id_rs/rt_used ID source operands
//                id_wb_addr, id_wb_wen        ID destination
//                id_mem_ren, id_is_branch     ID load / branch flags
//                exe/mem/wb _en, _rst         controller stage controls
//                exe_branch_taken             EXE branch resolved taken
//                reg_stall, flush_req         hazard direction
//                fwd_a_sel, fwd_b_sel         operand forwarding selects
//                stall_cnt, flush_cnt         saturating event counters
//  Revision    : 1.0 - initial release
// ============================================================================
import hazard_unit_pkg::*;

module hazard_unit #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [ADDR_W-1:0] id_wb_addr,
  input  logic              id_wb_wen,
  input  logic              id_mem_ren,
  input  logic              id_is_branch,
  input  logic              exe_en,
  input  logic              exe_rst,
  input  logic              mem_en,
  input  logic              mem_rst,
  input  logic              wb_en,
  input  logic              wb_rst,
  input  logic              exe_branch_taken,
  output logic              reg_stall,
  output logic              flush_req,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  sb_flags_t         w_id_flags, w_exe_flags, w_mem_flags, w_wb_flags;
  logic [ADDR_W-1:0] w_exe_addr, w_mem_addr, w_wb_addr;
  logic              w_stall_raw;

  always_comb begin
    w_id_flags           = SB_BUBBLE;
    w_id_flags.valid     = 1'b1;
    w_id_flags.wen       = id_wb_wen;
    w_id_flags.mem_ren   = id_mem_ren;
    w_id_flags.is_branch = id_is_branch;
  end

  // EXE takes a bubble whenever the instruction in ID is being held back.
  hazard_sb_entry #(.ADDR_W(ADDR_W)) u_sb_exe (
    .clk(clk), .rst_n(rst_n),
    .stage_rst_i(exe_rst), .stage_en_i(exe_en), .bubble_i(reg_stall),
    .addr_i(id_wb_addr), .flags_i(w_id_flags),
    .addr_o(w_exe_addr), .flags_o(w_exe_flags)
  );

  hazard_sb_entry #(.ADDR_W(ADDR_W)) u_sb_mem (
    .clk(clk), .rst_n(rst_n),
    .stage_rst_i(mem_rst), .stage_en_i(mem_en), .bubble_i(1'b0),
    .addr_i(w_exe_addr), .flags_i(w_exe_flags),
    .addr_o(w_mem_addr), .flags_o(w_mem_flags)
  );

  hazard_sb_entry #(.ADDR_W(ADDR_W)) u_sb_wb (
    .clk(clk), .rst_n(rst_n),
    .stage_rst_i(wb_rst), .stage_en_i(wb_en), .bubble_i(1'b0),
    .addr_i(w_mem_addr), .flags_i(w_mem_flags),
    .addr_o(w_wb_addr), .flags_o(w_wb_flags)
  );

  // --------------------------------------------------------------------------
  // Dependency detection
  // --------------------------------------------------------------------------
  logic w_exe_wr, w_mem_wr, w_wb_wr;
  logic w_rs_exe, w_rt_exe, w_rs_mem, w_rt_mem, w_rs_wb, w_rt_wb;

  assign w_exe_wr = entry_writes(w_exe_flags, |w_exe_addr);
  assign w_mem_wr = entry_writes(w_mem_flags, |w_mem_addr);
  assign w_wb_wr  = entry_writes(w_wb_flags,  |w_wb_addr);

  assign w_rs_exe = id_rs_used & (id_rs_addr == w_exe_addr);
  assign w_rt_exe = id_rt_used & (id_rt_addr == w_exe_addr);
  assign w_rs_mem = id_rs_used & (id_rs_addr == w_mem_addr);
  assign w_rt_mem = id_rt_used & (id_rt_addr == w_mem_addr);
  assign w_rs_wb  = id_rs_used & (id_rs_addr == w_wb_addr);
  assign w_rt_wb  = id_rt_used & (id_rt_addr == w_wb_addr);

`ifdef HAZARD_FORWARD_EN
  // A load in MEM has no result yet; its consumer was already stalled a cycle
  // and picks the value up from WB instead.
  logic w_mem_fwd_ok;
  assign w_mem_fwd_ok = w_mem_wr & ~w_mem_flags.mem_ren;

  assign w_stall_raw = w_exe_wr & w_exe_flags.mem_ren & (w_rs_exe | w_rt_exe);
  assign fwd_a_sel   = fwd_select(w_mem_fwd_ok & w_rs_mem, w_wb_wr & w_rs_wb);
  assign fwd_b_sel   = fwd_select(w_mem_fwd_ok & w_rt_mem, w_wb_wr & w_rt_wb);
`else
  // No bypass network: wait until the producer has left WB, since a
  // same-cycle register-file write/read is not assumed to pass through.
  assign w_stall_raw = (w_exe_wr & (w_rs_exe | w_rt_exe))
                     | (w_mem_wr & (w_rs_mem | w_rt_mem))
                     | (w_wb_wr  & (w_rs_wb  | w_rt_wb));
  assign fwd_a_sel   = FWD_REG;
  assign fwd_b_sel   = FWD_REG;
`endif

  // Only part of the MEM/WB flag records feeds the hazard logic.
  logic w_unused_flags;
  assign w_unused_flags = ^{w_mem_flags, w_wb_flags};

  // A taken branch squashes the ID instruction, so its stall is moot.
  assign flush_req = w_exe_flags.valid & w_exe_flags.is_branch & exe_branch_taken;
  assign reg_stall = w_stall_raw & ~flush_req;

  // --------------------------------------------------------------------------
  // Saturating event counters
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (reg_stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_req && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire
